// File: rtl/axis_eth_fcs_check.sv
// ---------------------------------------------------------------------------
// axis_eth_fcs_check
//
// Receive-side Ethernet FCS checker. Sits directly behind the MII nibble-to-
// byte converter in the same clock domain. It takes frame bytes from the
// destination MAC through the last FCS byte, runs CRC-32 over every byte,
// strips the 4 FCS bytes through a 4-deep delay FIFO and re-emits the
// payload. Frame status is reported on the last payload beat and as
// one-cycle statistics pulses.
//
// Handshake: valid-only streams. A beat transfers on every clock edge where
// tvalid=1. There is no tready on either side because the MII receive path
// cannot stall. Input beats may have idle gaps between them. An output beat
// is produced exactly one cycle after the input beat that pops it.
//
// Ports
//   clock, reset   single clock; synchronous active-high reset
//   saxis_tdata    received frame byte
//   saxis_tvalid   input byte valid
//   saxis_tuser    upstream error for this beat
//   saxis_tlast    last byte of the frame (last FCS byte)
//   maxis_tdata    frame byte with the FCS removed
//   maxis_tvalid   output byte valid
//   maxis_tuser    frame error; only meaningful together with maxis_tlast
//   maxis_tlast    last payload byte of the frame
//   stat_good      pulse: frame passed every check
//   stat_crc_err   pulse: FCS mismatch
//   stat_len_err   pulse: runt or oversize frame
//   stat_drop      pulse: frame of 4 bytes or fewer discarded
// ---------------------------------------------------------------------------
module axis_eth_fcs_check #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_WIDTH     = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] saxis_tdata,
  input  logic       saxis_tvalid,
  input  logic       saxis_tuser,
  input  logic       saxis_tlast,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  output logic       maxis_tuser,
  output logic       maxis_tlast,
  output logic       stat_good,
  output logic       stat_crc_err,
  output logic       stat_len_err,
  output logic       stat_drop
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value after running the CRC over data plus its own FCS,
  // without the final inversion.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [LEN_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN   = LEN_WIDTH'(MIN_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_FRAME_LEN);

  // One byte of the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0]          crc_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [2:0]           fill_q;
  logic                 error_sticky_q;
  logic [7:0]           fifo_q [0:3];  // fifo_q[0] is the oldest byte

  logic [31:0]          crc_next;
  logic [LEN_WIDTH-1:0] len_next;
  logic                 pop;
  logic                 crc_err;
  logic                 len_err;
  logic                 frame_err;

  always_comb begin
    crc_next  = crc_byte(crc_q, saxis_tdata);
    len_next  = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
    // Once four bytes are held, every new byte pushes the oldest one out;
    // this is what keeps the trailing 4 FCS bytes from ever being emitted.
    pop       = (fill_q == 3'd4);
    crc_err   = (crc_next != CRC_RESIDUE);
    len_err   = (len_next < MIN_LEN) || (len_next > MAX_LEN);
    frame_err = crc_err | len_err | error_sticky_q | saxis_tuser;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q          <= CRC_INIT;
      count_q        <= '0;
      fill_q         <= 3'd0;
      error_sticky_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'd0;
      maxis_tdata    <= 8'd0;
      maxis_tvalid   <= 1'b0;
      maxis_tuser    <= 1'b0;
      maxis_tlast    <= 1'b0;
      stat_good      <= 1'b0;
      stat_crc_err   <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_drop      <= 1'b0;
    end else begin
      // Outputs are single-cycle: cleared unless this edge produces a beat.
      maxis_tdata  <= 8'd0;
      maxis_tvalid <= 1'b0;
      maxis_tuser  <= 1'b0;
      maxis_tlast  <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_drop    <= 1'b0;

      if (saxis_tvalid) begin
        if (pop) begin
          maxis_tvalid <= 1'b1;
          maxis_tdata  <= fifo_q[0];
          for (int i = 0; i < 3; i++) fifo_q[i] <= fifo_q[i+1];
          fifo_q[3] <= saxis_tdata;
        end else begin
          fifo_q[fill_q[1:0]] <= saxis_tdata;
          fill_q              <= fill_q + 3'd1;
        end

        if (saxis_tlast) begin
          // Frame done: return to the idle state so a following beat,
          // even on the very next cycle, starts a fresh frame.
          crc_q          <= CRC_INIT;
          count_q        <= '0;
          fill_q         <= 3'd0;
          error_sticky_q <= 1'b0;
          if (pop) begin
            maxis_tlast  <= 1'b1;
            maxis_tuser  <= frame_err;
            stat_crc_err <= crc_err;
            stat_len_err <= len_err;
            stat_good    <= ~frame_err;
          end else begin
            // Four bytes or fewer: nothing was ever emitted for this frame.
            stat_drop <= 1'b1;
          end
        end else begin
          crc_q          <= crc_next;
          count_q        <= len_next;
          error_sticky_q <= error_sticky_q | saxis_tuser;
        end
      end
    end
  end

endmodule

// File: doc/axis_eth_fcs_check.md
Name: axis_eth_fcs_check

Overview:
- Byte-stream stage directly downstream of the MII receive nibble-to-byte converter, in the same clock domain.
- Consumes received Ethernet frame bytes, from destination MAC through FCS, with preamble and SFD already removed.
- Computes CRC-32 over every byte and strips the 4 FCS bytes. Re-emits the frame payload with an error flag on the last beat.
- No backpressure on either side, because the MII receive path cannot stall.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes, FCS included; shorter frames are flagged.
- MAX_FRAME_LEN, 1518, maximum legal frame length in bytes, FCS included; longer frames are flagged.
- LEN_WIDTH, 11, width of the frame byte counter; must hold MAX_FRAME_LEN+1.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- saxis_tdata  in  8  received frame byte.
- saxis_tvalid  in  1  byte valid; may have idle gaps between beats (typically every other cycle).
- saxis_tuser  in  1  upstream error for this beat.
- saxis_tlast  in  1  final byte of frame (last FCS byte).
- maxis_tdata  out  8  frame byte with FCS removed.
- maxis_tvalid  out  1  output byte valid.
- maxis_tuser  out  1  frame error; meaningful only with maxis_tlast.
- maxis_tlast  out  1  last payload byte of frame.
- stat_good  out  1  one-cycle pulse: frame passed all checks.
- stat_crc_err  out  1  one-cycle pulse: FCS mismatch.
- stat_len_err  out  1  one-cycle pulse: runt or oversize frame.
- stat_drop  out  1  one-cycle pulse: frame of 4 bytes or fewer discarded.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - CRC register 0xFFFFFFFF.
  - Byte count 0; FIFO fill level 0; error_sticky 0.
- Reset mid-frame discards the partial frame silently and emits no tlast. The block is idle until the next input beat, which starts a new frame.
- Input beat (saxis_tvalid=1):
  - crc_next = CRC-32 step of crc with the input byte, reflected polynomial 0xEDB88320, LSB first.
  - Byte count increments and saturates at 2^LEN_WIDTH-1.
  - error_sticky |= saxis_tuser.
- FCS stripping uses a 4-entry delay FIFO. On an input beat:
  - If the fill level is 4, the oldest byte is emitted and the new byte is pushed.
  - Otherwise the new byte is pushed and the fill level increments.
- Latency: an emitted byte appears on maxis_* one cycle after the input beat that caused it. All outputs are registered.
- Output valid: maxis_tvalid=1 only on cycles following such a pop; it is 0 on all other cycles, including input gaps.
- Frame end is an input beat with saxis_tlast=1. Let len be the count including this byte.
  - len >= 5: a pop occurs on this beat and the popped byte is output with maxis_tlast=1.
  - maxis_tuser on that last beat = crc_err | len_err | error_sticky | saxis_tuser.
  - crc_err = (crc_next != 0xDEBB20E3), the residue after the FCS bytes with no final inversion.
  - len_err = (len < MIN_FRAME_LEN) or (len > MAX_FRAME_LEN).
  - Stat pulses in the same cycle as the output tlast:
    - stat_crc_err = crc_err.
    - stat_len_err = len_err.
    - stat_good = !maxis_tuser.
  - len <= 4: nothing is emitted for the frame (no byte was ever popped) and stat_drop pulses one cycle later.
  - In every case, the cycle after tlast has CRC=0xFFFFFFFF, count=0, fill=0, error_sticky=0. The next input beat is the first byte of a new frame. Back-to-back frames with no gap cycle are supported.
- The input stream never carries tvalid without a frame in progress. A frame with no tlast runs indefinitely; the count saturates and the frame is later flagged as len_err.
- maxis_tuser and maxis_tlast are 0 on non-last beats.

Test Plan:
- 64-byte frame (60 bytes 0x00..0x3B + correct FCS), one beat per cycle.
  -> 60 output beats with the same data in order. tlast on the 60th beat, tuser=0, stat_good pulse, no other stat pulses.
- Same frame with bit 0 of byte 10 flipped.
  -> 60 beats, tlast tuser=1, stat_crc_err=1, stat_good=0.
- 40-byte frame with correct FCS, tvalid every other cycle.
  -> 36 beats each one cycle after its input beat, tlast tuser=1, stat_len_err=1, stat_crc_err=0.
- 3-byte frame followed immediately (no gap) by the 64-byte good frame.
  -> zero output beats for the first frame and a stat_drop pulse; the second frame passes as in scenario 1.
- 64-byte good frame with saxis_tuser=1 on byte 20 only.
  -> tlast tuser=1, stat_good=0, stat_crc_err=0, stat_len_err=0.
- reset asserted for 1 cycle at byte 30 of a frame, then a good 64-byte frame.
  -> outputs 0 during reset, no tlast for the aborted frame, second frame passes cleanly.
